// File: rtl/rvm_mem_responder_pkg.sv
// Shared constants for rvm_mem_responder: FSM state encodings, the read code on mem_b_en,
// and the address legality check used by both configurations.
package rvm_mem_responder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } rvm_state_e;

    localparam logic [3:0] BenRead = 4'b0000;

    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // 33-bit limit so a window ending at 4 GiB does not wrap.
    function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] base,
                                      input int unsigned depth);
        logic [32:0] limit;
        limit = {1'b0, base} + ({1'b0, 32'(depth)} << 2);
        return (addr < base) || ({1'b0, addr} >= limit) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/rvm_mem_array.sv
// Word storage for rvm_mem_responder: synchronous 4-lane byte-write port and an
// asynchronous read port sharing one word address. Contents are never reset.
module rvm_mem_array
    import rvm_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned IdxW = idx_w(DEPTH_WORDS)
) (
    input  logic            clk_i,
    input  logic [3:0]      be_i,
    input  logic [IdxW-1:0] addr_i,
    input  logic [31:0]     wdata_i,
    output logic [31:0]     rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/rvm_mem_responder.sv
// Memory responder for a simple core bus. With RVM_MEM_WAIT_STATES_EN defined it inserts
// WAIT_CYCLES wait states through an IDLE/WAIT/RESP FSM; otherwise it answers combinationally.
module rvm_mem_responder
    import rvm_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    input  logic [31:0] mem_wdata,
    input  logic        mem_c_en,
    input  logic [3:0]  mem_b_en,
    output logic        mem_error,
    output logic        mem_stall
);

    localparam int unsigned IdxW = idx_w(DEPTH_WORDS);

    logic [3:0]      arr_be;
    logic [IdxW-1:0] arr_idx;
    logic [31:0]     arr_wdata;
    logic [31:0]     arr_rdata;

    rvm_mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk_i  (clk),
        .be_i   (arr_be),
        .addr_i (arr_idx),
        .wdata_i(arr_wdata),
        .rdata_o(arr_rdata)
    );

`ifdef RVM_MEM_WAIT_STATES_EN
    localparam logic [3:0] WaitCnt = 4'(WAIT_CYCLES);

    rvm_state_e  state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  ben_q;
    logic [31:0] rdata_q;
    logic        error_q;

    logic [31:0] acc_addr;
    logic [3:0]  acc_ben;
    logic        acc_err;
    logic        enter_resp;

    // With zero wait states the access completes on the capture edge, so the array
    // sees the live request in IDLE and the captured one in WAIT.
    always_comb begin
        acc_addr   = (state_q == StIdle) ? mem_addr : addr_q;
        acc_ben    = (state_q == StIdle) ? mem_b_en : ben_q;
        arr_wdata  = (state_q == StIdle) ? mem_wdata : wdata_q;
        acc_err    = addr_err(acc_addr, BASE_ADDR, DEPTH_WORDS);
        arr_idx    = IdxW'((acc_addr - BASE_ADDR) >> 2);
        enter_resp = mem_c_en && (((state_q == StIdle) && (WaitCnt == 4'd0)) ||
                                  ((state_q == StWait) && (cnt_q == 4'd1)));
        arr_be     = (enter_resp && !acc_err) ? acc_ben : BenRead;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            ben_q   <= 4'h0;
            rdata_q <= 32'h0;
            error_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (mem_c_en) begin
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        ben_q   <= mem_b_en;
                        cnt_q   <= WaitCnt;
                        state_q <= enter_resp ? StResp : StWait;
                    end
                end
                StWait: begin
                    if (!mem_c_en) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (enter_resp) begin
                            state_q <= StResp;
                        end
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    rdata_q <= 32'h0;
                    error_q <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
            if (enter_resp) begin
                rdata_q <= (acc_err || (acc_ben != BenRead)) ? 32'h0 : arr_rdata;
                error_q <= acc_err;
            end
        end
    end

    assign mem_stall = mem_c_en && (state_q != StResp);
    assign mem_rdata = rdata_q;
    assign mem_error = error_q;
`else
    logic acc_err;
    logic unused_cfg;

    always_comb begin
        acc_err   = addr_err(mem_addr, BASE_ADDR, DEPTH_WORDS);
        arr_idx   = IdxW'((mem_addr - BASE_ADDR) >> 2);
        arr_wdata = mem_wdata;
        arr_be    = (mem_c_en && !acc_err) ? mem_b_en : BenRead;
    end

    assign mem_stall  = 1'b0;
    assign mem_error  = mem_c_en && acc_err;
    assign mem_rdata  = (mem_c_en && !acc_err && (mem_b_en == BenRead)) ? arr_rdata : 32'h0;
    // No registered state here, so reset and the wait-state count have no effect.
    assign unused_cfg = ^{resetn, 32'(WAIT_CYCLES)};
`endif

endmodule

// File: tb/tb_rvm_mem_responder.sv
// Randomized bench for rvm_mem_responder against a word-array reference model; follows
// the wait-state FSM when RVM_MEM_WAIT_STATES_EN is defined, the zero-wait path otherwise.
`timescale 1ns/1ps
module tb_rvm_mem_responder;

    localparam int unsigned Depth = 1024;
    localparam int unsigned Wait  = 2;
    localparam logic [31:0] Limit = 32'(4 * Depth);

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_c_en = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [3:0]  mem_b_en = 4'h0;
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic        mem_stall;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] ref_mem [Depth];

    rvm_mem_responder #(
        .DEPTH_WORDS(Depth),
        .BASE_ADDR  (32'h0000_0000),
        .WAIT_CYCLES(Wait)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata),
        .mem_c_en (mem_c_en),
        .mem_b_en (mem_b_en),
        .mem_error(mem_error),
        .mem_stall(mem_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected the run to finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic ref_err(input logic [31:0] a);
        return (a >= Limit) || (a[1:0] != 2'b00);
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        return int'((a >> 2) % Depth);
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        if (!ref_err(a)) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) ref_mem[ref_idx(a)][8*i +: 8] = wd[8*i +: 8];
            end
        end
    endtask

    // One complete access; rd returns the data seen in the response cycle.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                          input bit scramble, output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic        exp_err;
        exp_err = ref_err(a);
        exp_rd  = (exp_err || be != 4'h0) ? 32'h0 : ref_mem[ref_idx(a)];
        @(negedge clk);
        mem_c_en  = 1'b1;
        mem_addr  = a;
        mem_wdata = wd;
        mem_b_en  = be;
        #1;
`ifdef RVM_MEM_WAIT_STATES_EN
        begin
            int stalls;
            stalls = 0;
            while (mem_stall && stalls <= int'(Wait) + 4) begin
                check_eq("stall_rdata", mem_rdata, 32'h0);
                check_eq("stall_error", 32'(mem_error), 32'h0);
                stalls++;
                @(negedge clk);
                #1;
                if (scramble) begin
                    mem_addr  = $urandom;
                    mem_wdata = $urandom;
                    mem_b_en  = 4'($urandom);
                end
            end
            check_eq("latency", 32'(stalls), 32'(Wait + 1));
        end
`endif
        check_eq("stall_resp", 32'(mem_stall), 32'h0);
        check_eq("error", 32'(mem_error), 32'(exp_err));
        if (be == 4'h0) check_eq("rdata", mem_rdata, exp_rd);
        rd = mem_rdata;
        ref_write(a, wd, be);
        @(posedge clk);
        #1;
        mem_c_en = 1'b0;
    endtask

    logic [31:0] rd;
    logic [31:0] ra;
    logic [3:0]  rbe;
    int          sel;
    int          guard;

    initial begin
        repeat (3) @(negedge clk);
        check_eq("reset_rdata", mem_rdata, 32'h0);
        check_eq("reset_error", 32'(mem_error), 32'h0);
        check_eq("reset_stall", 32'(mem_stall), 32'h0);
        resetn = 1'b1;

        for (int i = 0; i < int'(Depth); i++) access(32'(i) * 4, $urandom, 4'hF, 1'b0, rd);

        access(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd);
        access(32'h10, 32'h0, 4'h0, 1'b0, rd);
        check_eq("write_read_lit", rd, 32'hDEADBEEF);
        access(32'h10, 32'h0000AA00, 4'b0010, 1'b0, rd);
        access(32'h10, 32'h0, 4'h0, 1'b0, rd);
        check_eq("partial_lit", rd, 32'hDEADAAEF);

        access(32'h1002, 32'h0, 4'h0, 1'b0, rd);
        access(Limit, 32'h0, 4'h0, 1'b0, rd);
        access(Limit - 4, 32'h0, 4'h0, 1'b0, rd);
        access(Limit, 32'h1234_5678, 4'hF, 1'b0, rd);
        access(32'h0, 32'h0, 4'h0, 1'b0, rd);
        check_eq("oob_write_alias", rd, ref_mem[0]);

`ifdef RVM_MEM_WAIT_STATES_EN
        // Drop the request while the write to 0x20 is still waiting.
        @(negedge clk);
        mem_c_en = 1'b1; mem_addr = 32'h20; mem_wdata = ~ref_mem[8]; mem_b_en = 4'hF;
        @(negedge clk);
        mem_c_en = 1'b0;
        @(negedge clk);
        #1;
        check_eq("abort_error", 32'(mem_error), 32'h0);
        check_eq("abort_rdata", mem_rdata, 32'h0);
        access(32'h20, 32'h0, 4'h0, 1'b0, rd);

        // Reset while in WAIT.
        @(negedge clk);
        mem_c_en = 1'b1; mem_addr = 32'h10; mem_b_en = 4'h0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_eq("rst_wait_rdata", mem_rdata, 32'h0);
        check_eq("rst_wait_error", 32'(mem_error), 32'h0);
        mem_c_en = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check_eq("rst_release_stall", 32'(mem_stall), 32'h0);
        access(32'h10, 32'h0, 4'h0, 1'b0, rd);

        // Reset must clear the response asynchronously.
        @(negedge clk);
        mem_c_en = 1'b1; mem_addr = 32'h10; mem_b_en = 4'h0;
        #1;
        guard = 0;
        while (mem_stall && guard < int'(Wait) + 5) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check_eq("resp_before_rst", mem_rdata, 32'hDEADAAEF);
        resetn = 1'b0;
        #1;
        check_eq("rst_resp_rdata", mem_rdata, 32'h0);
        mem_c_en = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
`else
        // Back-to-back reads with the request held high.
        @(negedge clk);
        mem_c_en = 1'b1; mem_addr = 32'h0; mem_b_en = 4'h0;
        #1;
        check_eq("b2b_rdata0", mem_rdata, ref_mem[0]);
        check_eq("b2b_stall0", 32'(mem_stall), 32'h0);
        @(negedge clk);
        mem_addr = 32'h4;
        #1;
        check_eq("b2b_rdata1", mem_rdata, ref_mem[1]);
        check_eq("b2b_stall1", 32'(mem_stall), 32'h0);
        @(negedge clk);
        mem_c_en = 1'b0;
        #1;
        check_eq("idle_rdata", mem_rdata, 32'h0);
`endif

        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 7) ra = 32'($urandom_range(0, Depth - 1)) * 4;
            else if (sel == 7) ra = 32'($urandom_range(0, Depth - 1)) * 4 + 32'($urandom_range(1, 3));
            else if (sel == 8) ra = Limit + 32'($urandom_range(0, 255)) * 4;
            else ra = $urandom;
            rbe = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            access(ra, $urandom, rbe, $urandom_range(0, 3) == 0, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
